// File: rtl/usb_cmd_frame_parser.sv
// Framed host-command parser for the CDC bulk-OUT byte stream: AA 55 CMD LEN_H LEN_L PAYLOAD CHK.
// Optional inter-byte timeout is built when CMD_PARSER_TIMEOUT_EN is defined.
module usb_cmd_frame_parser #(
  parameter int unsigned MAX_PAYLOAD    = 256,
  parameter int unsigned BUF_AW         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 6000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              cmd_valid,
  output logic [7:0]        cmd_type,
  output logic [15:0]       cmd_len,
  input  logic              cmd_ack,
  input  logic [BUF_AW-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int unsigned Depth  = 1 << BUF_AW;
  localparam logic [15:0] MaxLen = 16'(MAX_PAYLOAD);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StHdr2 = 3'd1;
  localparam logic [2:0] StCmd  = 3'd2;
  localparam logic [2:0] StLenH = 3'd3;
  localparam logic [2:0] StLenL = 3'd4;
  localparam logic [2:0] StData = 3'd5;
  localparam logic [2:0] StChk  = 3'd6;
  localparam logic [2:0] StPend = 3'd7;

  localparam logic [1:0] ErrChk     = 2'd0;
  localparam logic [1:0] ErrLen     = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
  localparam logic [1:0] ErrDrop    = 2'd3;

  // Elaboration-time sanity check on the configuration.
  if ((Depth < MAX_PAYLOAD) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("usb_cmd_frame_parser: buffer too small or timeout too short");
  end

  logic [2:0]  state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_type_q, cmd_type_d;
  logic [15:0] cmd_len_q, cmd_len_d;
  logic [15:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]  sum_q, sum_d;
  logic        err_pulse_q, err_pulse_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  rd_data_q;

  logic        buf_we;
  logic [15:0] len_full;
  logic        last_byte;
  logic        busy_w;

  logic [7:0]  buf_mem [Depth];

  assign busy_w    = (state_q != StIdle) && (state_q != StPend);
  assign len_full  = {cmd_len_q[15:8], rx_data};
  assign last_byte = (wr_ptr_q == (cmd_len_q - 16'd1));

`ifdef CMD_PARSER_TIMEOUT_EN
  localparam logic [31:0] ToLast = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        to_fire;

  // A byte landing in the terminal cycle wins over the timeout.
  assign to_fire  = busy_w && !rx_valid && (to_cnt_q == ToLast);
  assign to_cnt_d = (rx_valid || !busy_w || to_fire) ? 32'd0 : to_cnt_q + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= 32'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic to_fire;
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_type_d  = cmd_type_q;
    cmd_len_d   = cmd_len_q;
    wr_ptr_d    = wr_ptr_q;
    sum_d       = sum_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    if (state_q == StPend) begin
      if (cmd_ack) begin
        // Release and treat a coincident byte as an IDLE-state byte.
        cmd_valid_d = 1'b0;
        state_d     = (rx_valid && (rx_data == 8'hAA)) ? StHdr2 : StIdle;
      end else if (rx_valid) begin
        err_pulse_d = 1'b1;
        err_code_d  = ErrDrop;
      end
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == 8'hAA) state_d = StHdr2;
        end
        StHdr2: begin
          if (rx_data == 8'h55) begin
            state_d  = StCmd;
            wr_ptr_d = 16'd0;
            sum_d    = 8'd0;
          end else if (rx_data != 8'hAA) begin
            state_d = StIdle;
          end
        end
        StCmd: begin
          cmd_type_d = rx_data;
          sum_d      = rx_data;
          state_d    = StLenH;
        end
        StLenH: begin
          cmd_len_d[15:8] = rx_data;
          sum_d           = sum_q + rx_data;
          state_d         = StLenL;
        end
        StLenL: begin
          cmd_len_d[7:0] = rx_data;
          sum_d          = sum_q + rx_data;
          if (len_full > MaxLen) begin
            state_d     = StIdle;
            err_pulse_d = 1'b1;
            err_code_d  = ErrLen;
          end else if (len_full == 16'd0) begin
            state_d = StChk;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 16'd1;
          sum_d    = sum_q + rx_data;
          if (last_byte) state_d = StChk;
        end
        StChk: begin
          if (rx_data == sum_q) begin
            state_d     = StPend;
            cmd_valid_d = 1'b1;
          end else begin
            state_d     = StIdle;
            err_pulse_d = 1'b1;
            err_code_d  = ErrChk;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (to_fire) begin
      state_d     = StIdle;
      err_pulse_d = 1'b1;
      err_code_d  = ErrTimeout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= 8'h00;
      cmd_len_q   <= 16'h0000;
      wr_ptr_q    <= 16'd0;
      sum_q       <= 8'd0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_len_q   <= cmd_len_d;
      wr_ptr_q    <= wr_ptr_d;
      sum_q       <= sum_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      rd_data_q   <= buf_mem[rd_addr];
    end
  end

  // Payload RAM has no reset; only DATA writes it.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_ptr_q[BUF_AW-1:0]] <= rx_data;
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_len   = cmd_len_q;
  assign rd_data   = rd_data_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign busy      = busy_w;

endmodule
